axis_packet_gen: RTL and testbench

AXI-Stream packet generator that sits directly upstream of the NoC output sink and produces the traffic it consumes and logs. On a START request it emits a programmed number of multi-beat packets with deterministic payload, destination, ID and TLAST framing. It honours master-side backpressure, inserts a programmable idle gap between packets, and reports completion via BUSY and DONE.

---
 rtl/axis_packet_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_axis_packet_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_gen.sv
// rtl/axis_packet_gen.sv - AXI-Stream multi-beat packet generator with gap and completion flags
//
// Emits num_pkts packets of pkt_len beats (0 counts as 1) on a master AXI-Stream
// port after a start request, with gap idle cycles between packets.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             run request, honoured only in IDLE or DONE
//   num_pkts          packets per run, latched on start
//   pkt_len           beats per packet, latched on start
//   gap               idle cycles between packets, latched on start
//   base_dest         tdest of packet 0, latched on start
//   busy              high while a run is in progress
//   done              sticky completion flag, cleared by the next accepted start
//   axis_m_*          master stream: tvalid/tready/tdata/tlast/tid/tdest

module axis_packet_gen #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int TIDW   = 2,
    parameter int LENW   = 8,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNTW-1:0]   num_pkts,
    input  logic [LENW-1:0]   pkt_len,
    input  logic [LENW-1:0]   gap,
    input  logic [TDESTW-1:0] base_dest,
    output logic              busy,
    output logic              done,
    output logic              axis_m_tvalid,
    input  logic              axis_m_tready,
    output logic [TDATAW-1:0] axis_m_tdata,
    output logic              axis_m_tlast,
    output logic [TIDW-1:0]   axis_m_tid,
    output logic [TDESTW-1:0] axis_m_tdest
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Run configuration captured on an accepted start
    logic [CNTW-1:0]   num_q,  num_d;
    logic [LENW-1:0]   len_q,  len_d;
    logic [LENW-1:0]   gap_q,  gap_d;
    logic [TDESTW-1:0] base_q, base_d;

    // Progress counters
    logic [LENW-1:0]   beat_q, beat_d;
    logic [CNTW-1:0]   pkt_q,  pkt_d;
    logic [TDATAW-1:0] data_q, data_d;
    logic [LENW-1:0]   gcnt_q, gcnt_d;

    // Registered outputs
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              tvalid_q, tvalid_d;
    logic [TDATAW-1:0] tdata_q,  tdata_d;
    logic              tlast_q,  tlast_d;
    logic [TIDW-1:0]   tid_q,    tid_d;
    logic [TDESTW-1:0] tdest_q,  tdest_d;

    logic [LENW-1:0]   eff_len_in;
    logic [CNTW-1:0]   pkt_nxt;
    logic [LENW-1:0]   beat_nxt;
    logic [TDATAW-1:0] data_nxt;
    logic              xfer;

    assign eff_len_in = (pkt_len == '0) ? LENW'(1) : pkt_len;
    assign pkt_nxt    = pkt_q + CNTW'(1);
    assign beat_nxt   = beat_q + LENW'(1);
    assign data_nxt   = data_q + TDATAW'(1);
    // tvalid is a register, so the handshake never feeds back into it combinationally
    assign xfer       = tvalid_q && axis_m_tready;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        len_d    = len_q;
        gap_d    = gap_q;
        base_d   = base_q;
        beat_d   = beat_q;
        pkt_d    = pkt_q;
        data_d   = data_q;
        gcnt_d   = gcnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tid_d    = tid_q;
        tdest_d  = tdest_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_d  = num_pkts;
                    len_d  = eff_len_in;
                    gap_d  = gap;
                    base_d = base_dest;
                    beat_d = '0;
                    pkt_d  = '0;
                    data_d = '0;
                    gcnt_d = '0;
                    done_d = 1'b0;
                    busy_d = 1'b1;
                    if (num_pkts == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_SEND;
                        tvalid_d = 1'b1;
                        tdata_d  = '0;
                        tlast_d  = (eff_len_in == LENW'(1));
                        tid_d    = '0;
                        tdest_d  = base_dest;
                    end
                end
            end

            S_SEND: begin
                if (xfer) begin
                    data_d = data_nxt;
                    if (tlast_q) begin
                        if (pkt_q == num_q - CNTW'(1)) begin
                            state_d  = S_DONE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            pkt_d  = pkt_nxt;
                            beat_d = '0;
                            if (gap_q == '0) begin
                                // Back-to-back packet: present its first beat immediately
                                tdata_d = data_nxt;
                                tlast_d = (len_q == LENW'(1));
                                tid_d   = pkt_nxt[TIDW-1:0];
                                tdest_d = base_q + pkt_nxt[TDESTW-1:0];
                            end else begin
                                state_d  = S_GAP;
                                tvalid_d = 1'b0;
                                tlast_d  = 1'b0;
                                gcnt_d   = gap_q;
                            end
                        end
                    end else begin
                        beat_d  = beat_nxt;
                        tdata_d = data_nxt;
                        tlast_d = (beat_nxt == len_q - LENW'(1));
                    end
                end
            end

            S_GAP: begin
                // gcnt runs gap..1, one idle cycle each; the next packet's first
                // beat is loaded while leaving the count-1 cycle.
                if (gcnt_q == LENW'(1)) begin
                    state_d  = S_SEND;
                    gcnt_d   = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = data_q;
                    tlast_d  = (len_q == LENW'(1));
                    tid_d    = pkt_q[TIDW-1:0];
                    tdest_d  = base_q + pkt_q[TDESTW-1:0];
                end else begin
                    gcnt_d = gcnt_q - LENW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            len_q    <= '0;
            gap_q    <= '0;
            base_q   <= '0;
            beat_q   <= '0;
            pkt_q    <= '0;
            data_q   <= '0;
            gcnt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tid_q    <= '0;
            tdest_q  <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            len_q    <= len_d;
            gap_q    <= gap_d;
            base_q   <= base_d;
            beat_q   <= beat_d;
            pkt_q    <= pkt_d;
            data_q   <= data_d;
            gcnt_q   <= gcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tid_q    <= tid_d;
            tdest_q  <= tdest_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign axis_m_tvalid = tvalid_q;
    assign axis_m_tdata  = tdata_q;
    assign axis_m_tlast  = tlast_q;
    assign axis_m_tid    = tid_q;
    assign axis_m_tdest  = tdest_q;

endmodule

// File: tb/tb_axis_packet_gen.sv
// tb/tb_axis_packet_gen.sv - self-checking bench for axis_packet_gen

module tb_axis_packet_gen;

    localparam int TDATAW = 32;
    localparam int TDESTW = 4;
    localparam int TIDW   = 2;
    localparam int LENW   = 8;
    localparam int CNTW   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNTW-1:0]   num_pkts;
    logic [LENW-1:0]   pkt_len;
    logic [LENW-1:0]   gap;
    logic [TDESTW-1:0] base_dest;
    logic              busy;
    logic              done;
    logic              tvalid;
    logic              tready;
    logic [TDATAW-1:0] tdata;
    logic              tlast;
    logic [TIDW-1:0]   tid;
    logic [TDESTW-1:0] tdest;

    always #5 clk = ~clk;

    axis_packet_gen #(
        .TDATAW(TDATAW), .TDESTW(TDESTW), .TIDW(TIDW), .LENW(LENW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_pkts(num_pkts),
        .pkt_len(pkt_len), .gap(gap), .base_dest(base_dest),
        .busy(busy), .done(done),
        .axis_m_tvalid(tvalid), .axis_m_tready(tready), .axis_m_tdata(tdata),
        .axis_m_tlast(tlast), .axis_m_tid(tid), .axis_m_tdest(tdest)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // rmode: 0 = tready always 1, 1 = 1,0,1,0..., 2 = random
    // poke:  assert start with a different config mid-run (must be ignored)
    typedef struct {
        int num;
        int len;
        int gap;
        int base;
        int rmode;
        bit poke;
        int exp_beats;
    } vec_t;

    typedef struct {
        longint data;
        int     last;
        int     id;
        int     dest;
    } beat_t;

    beat_t q[$];

    // Reference: the full beat list of a run, straight from the packet rules
    task automatic build_model(input vec_t v);
        int     eff;
        longint k;
        beat_t  b;
        q.delete();
        eff = (v.len == 0) ? 1 : v.len;
        k = 0;
        for (int p = 0; p < v.num; p++) begin
            for (int i = 0; i < eff; i++) begin
                b.data = k % (longint'(1) << TDATAW);
                b.last = (i == eff - 1) ? 1 : 0;
                b.id   = p % (1 << TIDW);
                b.dest = (v.base + p) % (1 << TDESTW);
                q.push_back(b);
                k++;
            end
        end
    endtask

    task automatic run(input vec_t v);
        int                got;
        int                cyc;
        int                gap_run;
        bit                pend;
        logic              pv, pr, plast;
        logic [TDATAW-1:0] pdata;
        logic [TIDW-1:0]   pid;
        logic [TDESTW-1:0] pdest;
        beat_t             e;
        got = 0; cyc = 0; gap_run = 0; pend = 1'b0;

        build_model(v);
        chk("model_beats", q.size(), v.exp_beats);

        num_pkts  = CNTW'(v.num);
        pkt_len   = LENW'(v.len);
        gap       = LENW'(v.gap);
        base_dest = TDESTW'(v.base);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        if (v.num == 0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            for (int i = 0; i < 5; i++) begin
                chk("zero_tvalid", tvalid, 0);
                @(posedge clk); #1;
            end
            return;
        end

        chk("start_tvalid", tvalid, 1);
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);

        while (q.size() > 0 && cyc < 2000) begin
            cyc++;
            case (v.rmode)
                0:       tready = 1'b1;
                1:       tready = (cyc % 2) == 1;
                default: tready = 1'($urandom_range(0, 1));
            endcase
            if (v.poke && cyc == 2) begin
                start     = 1'b1;
                num_pkts  = 16'd7;
                pkt_len   = 8'd9;
                base_dest = 4'd3;
            end
            pv = tvalid; pr = tready; plast = tlast;
            pdata = tdata; pid = tid; pdest = tdest;
            @(posedge clk); #1;
            start = 1'b0;
            if (pv && pr) begin
                e = q.pop_front();
                got++;
                chk("tdata", pdata, e.data);
                chk("tlast", plast, e.last);
                chk("tid", pid, e.id);
                chk("tdest", pdest, e.dest);
                if (q.size() == 0) begin
                    chk("end_done", done, 1);
                    chk("end_busy", busy, 0);
                    chk("end_tvalid", tvalid, 0);
                end else if (plast) begin
                    pend = 1'b1;
                    gap_run = 0;
                end
            end else if (pv) begin
                chk("stall_hold", (tvalid && tdata == pdata && tlast == plast &&
                                   tid == pid && tdest == pdest) ? 1 : 0, 1);
            end
            if (pend) begin
                if (!tvalid) begin
                    gap_run++;
                    if (gap_run > 300) begin
                        chk("gap_timeout", gap_run, v.gap);
                        pend = 1'b0;
                    end
                end else begin
                    chk("gap_len", gap_run, v.gap);
                    pend = 1'b0;
                end
            end
        end
        if (q.size() != 0) chk("timeout_beats_left", q.size(), 0);
        chk("beat_count", got, v.exp_beats);
        tready = 1'b1;
        @(posedge clk); #1;
        chk("done_sticky", done, 1);
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        rst_n = 1'b0; start = 1'b0; tready = 1'b1;
        num_pkts = '0; pkt_len = '0; gap = '0; base_dest = '0;

        tbl[0] = '{2, 3, 0, 5, 0, 1'b0, 6};
        tbl[1] = '{2, 3, 0, 5, 1, 1'b0, 6};
        tbl[2] = '{2, 2, 3, 0, 0, 1'b0, 4};
        tbl[3] = '{0, 4, 1, 2, 0, 1'b0, 0};
        tbl[4] = '{3, 0, 0, 0, 0, 1'b0, 3};
        tbl[5] = '{5, 1, 0, 15, 0, 1'b0, 5};
        tbl[6] = '{3, 2, 1, 1, 1, 1'b0, 6};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tid", tid, 0);
        chk("rst_tdest", tdest, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) run(tbl[i]);

        for (int i = 0; i < 8; i++) begin
            rv.num   = $urandom_range(0, 4);
            rv.len   = $urandom_range(0, 5);
            rv.gap   = $urandom_range(0, 3);
            rv.base  = $urandom_range(0, 15);
            rv.rmode = 2;
            rv.poke  = 1'b0;
            rv.exp_beats = rv.num * ((rv.len == 0) ? 1 : rv.len);
            run(rv);
        end

        // Asynchronous reset in the middle of a packet
        num_pkts = 16'd3; pkt_len = 8'd4; gap = 8'd0; base_dest = 4'd9;
        tready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", tvalid, 0);
        chk("arst_tdata", tdata, 0);
        chk("arst_tlast", tlast, 0);
        chk("arst_tid", tid, 0);
        chk("arst_tdest", tdest, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Restart from zero; a start pulse during SEND must be ignored
        rv = '{1, 2, 0, 0, 1, 1'b1, 2};
        run(rv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
